// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the PWM peripheral slice.
//   PWM_CNT_W        width of the PWM period counter
//   DUTY_FULL        duty code that forces a solid-high output
//   PRESCALE_DEFAULT clk cycles per counter step (~3.0 kHz PWM from 10 MHz)
//   NUM_OUT          number of user outputs
//   out_mode_e       per-output drive mode, decoded by out_mode()
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_CNT_W        = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int PRESCALE_DEFAULT = 13;
  localparam int NUM_OUT          = 16;

  typedef enum logic [1:0] {
    OUT_OFF    = 2'd0,
    OUT_STATIC = 2'd1,
    OUT_PWM    = 2'd2
  } out_mode_e;

  // Output enable dominates; the PWM select only matters when enabled.
  function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
    out_mode_e m;
    if (!en_out)     m = OUT_OFF;
    else if (en_pwm) m = OUT_PWM;
    else             m = OUT_STATIC;
    return m;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// -----------------------------------------------------------------------------
// pwm_peripheral_if
// Configuration bundle from the SPI register block to the PWM peripheral.
// All signals are already registered in the clk domain by the SPI block.
//   en_reg_out_7_0 / en_reg_out_15_8  output enables
//   en_reg_pwm_7_0 / en_reg_pwm_15_8  PWM mode selects
//   pwm_duty_cycle                    shared duty, 0 = 0 %, 255 = 100 %
// Modports: master = register block (drives), slave = PWM peripheral.
// -----------------------------------------------------------------------------
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0]           en_reg_out_7_0;
  logic [7:0]           en_reg_out_15_8;
  logic [7:0]           en_reg_pwm_7_0;
  logic [7:0]           en_reg_pwm_15_8;
  logic [PWM_CNT_W-1:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8,
    output en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0, en_reg_out_15_8,
    input en_reg_pwm_7_0, en_reg_pwm_15_8,
    input pwm_duty_cycle
  );
endinterface

// File: rtl/pwm_peripheral_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Prescaler plus free-running 8-bit period counter for the PWM peripheral.
//   clk, rst_n        clock, asynchronous active-low reset
//   cnt_o             current period counter value
//   wrap_o            last clk of a period (tick with cnt == 255)
//   period_start_o    registered one-clk pulse, aligned with the registered
//                     outputs that show counter value 0
// -----------------------------------------------------------------------------
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] cnt_o,
  output logic                 wrap_o,
  output logic                 period_start_o
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0]          pre_q, pre_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 period_start_q, period_start_d;
  logic                 tick;

  // With PRESCALE = 1, PRE_MAX is 0 and tick is permanently high.
  assign tick   = (pre_q == PRE_MAX);
  assign wrap_o = tick && (cnt_q == DUTY_FULL);

  always_comb begin
    pre_d          = tick ? 16'd0 : pre_q + 16'd1;
    cnt_d          = tick ? cnt_q + 8'd1 : cnt_q;
    // Registered so the pulse lines up with the registered outputs.
    period_start_d = (pre_q == 16'd0) && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q          <= 16'd0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Drives 16 user outputs that are each off, statically on, or PWM-modulated
// at a shared duty cycle. The duty value is shadowed at period boundaries so
// register writes never cause glitches or runt pulses.
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg            configuration registers (pwm_peripheral_if.slave)
//   out            registered user outputs
//   period_start   one-clk pulse with the first output cycle of each period
// Parameter PRESCALE: clk cycles per counter step, legal 1..65535.
// -----------------------------------------------------------------------------
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_peripheral_if.slave    cfg,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  logic [PWM_CNT_W-1:0] cnt;
  logic                 wrap;

  logic [PWM_CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic                 load_pend_q;
  logic [NUM_OUT-1:0]   out_q, out_d;

  logic [NUM_OUT-1:0]   en_out, en_pwm;
  logic [PWM_CNT_W-1:0] duty_eff;
  logic                 pwm_sig;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .cnt_o          (cnt),
    .wrap_o         (wrap),
    .period_start_o (period_start)
  );

  assign en_out = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
  assign en_pwm = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};

  // On the first edge after reset the shadow still holds 0 while the counter
  // already sits at 0; comparing against the incoming value in that one cycle
  // keeps the first period's output consistent with every later period.
  assign duty_eff = load_pend_q ? cfg.pwm_duty_cycle : duty_sh_q;
  assign pwm_sig  = (duty_eff == DUTY_FULL) || (cnt < duty_eff);

  always_comb begin
    duty_sh_d = (load_pend_q || wrap) ? cfg.pwm_duty_cycle : duty_sh_q;
    out_d     = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      case (out_mode(en_out[i], en_pwm[i]))
        OUT_STATIC: out_d[i] = 1'b1;
        OUT_PWM:    out_d[i] = pwm_sig;
        default:    out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh_q   <= '0;
      load_pend_q <= 1'b1;
      out_q       <= '0;
    end else begin
      duty_sh_q   <= duty_sh_d;
      load_pend_q <= 1'b0;
      out_q       <= out_d;
    end
  end

  assign out = out_q;

endmodule
